// File: rtl/team_06_i2s_channel_scheduler.sv
// ---------------------------------------------------------------------------
// team_06_i2s_channel_scheduler
//
// Schedules two sample sources onto a stereo I2S stream for the DAC
// serializer. Source 0 feeds the left slot and source 1 feeds the right slot.
// Each source has a one-entry holding register behind a ready/valid handshake.
// The block derives the bit clock and word select from clk, and at every slot
// boundary it hands the serializer a parallel word with a one-cycle strobe.
//
// Ports
//   clk          system clock
//   rst          asynchronous active-high reset
//   en           stream enable
//   src0_data    left-slot sample          src0_valid / src0_ready  handshake
//   src1_data    right-slot sample         src1_valid / src1_ready  handshake
//   uf_clr       clears both underflow flags on the next edge
//   dac_word     parallel word to serializer, stable between loads
//   dac_load     one-cycle load strobe, the cycle after the load edge
//   ws           word select (0 = left, 1 = right)
//   bclk         bit clock, high for the second half of each bit period
//   bit_tick     pulse on the last clk of each bit period
//   underflow    sticky per-slot underflow ([0] = left, [1] = right)
//   busy         FSM is not idle
//
// State     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | counters parked at 0, ws/bclk low, waiting for en
// RUN       | streaming; each word end loads the other slot
// DRAIN     | en dropped mid-word; timing runs out to the word end
// ---------------------------------------------------------------------------
module team_06_i2s_channel_scheduler #(
  parameter int DATA_W      = 8,
  parameter int CLK_PER_BIT = 48
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] src0_data,
  input  logic              src0_valid,
  output logic              src0_ready,
  input  logic [DATA_W-1:0] src1_data,
  input  logic              src1_valid,
  output logic              src1_ready,
  input  logic              uf_clr,
  output logic [DATA_W-1:0] dac_word,
  output logic              dac_load,
  output logic              ws,
  output logic              bclk,
  output logic              bit_tick,
  output logic [1:0]        underflow,
  output logic              busy
);

  localparam int DIV_W = $clog2(CLK_PER_BIT);
  localparam int BIT_W = $clog2(DATA_W);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_PER_BIT - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_PER_BIT / 2);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              slot_q, slot_d;
  logic              ws_q, ws_d;
  logic              dac_load_q, dac_load_d;
  logic [DATA_W-1:0] dac_word_q, dac_word_d;
  logic [DATA_W-1:0] hold0_q, hold0_d;
  logic [DATA_W-1:0] hold1_q, hold1_d;
  logic              full0_q, full0_d;
  logic              full1_q, full1_d;
  logic [1:0]        underflow_q, underflow_d;

  logic timing_on;
  logic bit_tick_w;
  logic word_end_w;
  logic load_w;
  logic load_slot_w;

  // -------------------------------------------------------------------------
  // Bit timing decode
  // -------------------------------------------------------------------------
  always_comb begin
    timing_on  = (state_q != IDLE);
    bit_tick_w = timing_on && (div_cnt_q == DIV_LAST);
    word_end_w = bit_tick_w && (bit_cnt_q == BIT_LAST);
  end

  // -------------------------------------------------------------------------
  // FSM next-state, counters, slot/ws and load request
  // -------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    div_cnt_d   = div_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    slot_d      = slot_q;
    ws_d        = ws_q;
    load_w      = 1'b0;
    load_slot_w = slot_q;

    if (timing_on) begin
      div_cnt_d = bit_tick_w ? '0 : div_cnt_q + 1'b1;
      if (bit_tick_w) begin
        bit_cnt_d = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        div_cnt_d = '0;
        bit_cnt_d = '0;
        ws_d      = 1'b0;
        slot_d    = 1'b0;
        if (en) begin
          load_w      = 1'b1;
          load_slot_w = 1'b0;
          state_d     = RUN;
        end
      end

      RUN, DRAIN: begin
        if (word_end_w) begin
          if (en) begin
            // Counters already wrap to 0 here, so the next slot starts cleanly.
            load_w      = 1'b1;
            load_slot_w = ~slot_q;
            slot_d      = ~slot_q;
            ws_d        = ~slot_q;
            state_d     = RUN;
          end else begin
            div_cnt_d = '0;
            bit_cnt_d = '0;
            slot_d    = 1'b0;
            ws_d      = 1'b0;
            state_d   = IDLE;
          end
        end else begin
          // Re-enabling during DRAIN resumes without touching the counters.
          state_d = en ? RUN : DRAIN;
        end
      end

      default: begin
        div_cnt_d = '0;
        bit_cnt_d = '0;
        slot_d    = 1'b0;
        ws_d      = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Holding registers, load datapath and underflow flags
  // -------------------------------------------------------------------------
  always_comb begin
    hold0_d     = hold0_q;
    hold1_d     = hold1_q;
    full0_d     = full0_q;
    full1_d     = full1_q;
    dac_word_d  = dac_word_q;
    dac_load_d  = 1'b0;
    underflow_d = underflow_q;

    // Clear first so a set on the same edge wins.
    if (uf_clr) begin
      underflow_d = 2'b00;
    end

    if (load_w) begin
      dac_load_d = 1'b1;
      if (!load_slot_w) begin
        if (full0_q) begin
          dac_word_d = hold0_q;
          full0_d    = 1'b0;
        end else begin
          dac_word_d     = '0;
          underflow_d[0] = 1'b1;
        end
      end else begin
        if (full1_q) begin
          dac_word_d = hold1_q;
          full1_d    = 1'b0;
        end else begin
          dac_word_d     = '0;
          underflow_d[1] = 1'b1;
        end
      end
    end

    // Capture only when empty, so capture and consume never share an edge.
    if (src0_valid && !full0_q) begin
      hold0_d = src0_data;
      full0_d = 1'b1;
    end
    if (src1_valid && !full1_q) begin
      hold1_d = src1_data;
      full1_d = 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      div_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      slot_q      <= 1'b0;
      ws_q        <= 1'b0;
      dac_load_q  <= 1'b0;
      dac_word_q  <= '0;
      hold0_q     <= '0;
      hold1_q     <= '0;
      full0_q     <= 1'b0;
      full1_q     <= 1'b0;
      underflow_q <= 2'b00;
    end else begin
      state_q     <= state_d;
      div_cnt_q   <= div_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      slot_q      <= slot_d;
      ws_q        <= ws_d;
      dac_load_q  <= dac_load_d;
      dac_word_q  <= dac_word_d;
      hold0_q     <= hold0_d;
      hold1_q     <= hold1_d;
      full0_q     <= full0_d;
      full1_q     <= full1_d;
      underflow_q <= underflow_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign src0_ready = ~full0_q;
  assign src1_ready = ~full1_q;
  assign dac_word   = dac_word_q;
  assign dac_load   = dac_load_q;
  assign ws         = ws_q;
  // div_cnt is parked at 0 in IDLE, so bclk is low there without extra gating.
  assign bclk       = (div_cnt_q >= DIV_HALF);
  assign bit_tick   = bit_tick_w;
  assign underflow  = underflow_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_team_06_i2s_channel_scheduler.sv
// ---------------------------------------------------------------------------
// Testbench for team_06_i2s_channel_scheduler: a table of single-cycle
// vectors for reset/handshake/first load, then hand-written multi-cycle
// sequences for slot timing, underflow, backpressure, enable drop and reset.
// ---------------------------------------------------------------------------
module tb_team_06_i2s_channel_scheduler;

  localparam int DATA_W = 8;
  localparam int CPB    = 48;
  localparam int SLOT   = DATA_W * CPB;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              en = 1'b0;
  logic [DATA_W-1:0] src0_data = '0;
  logic              src0_valid = 1'b0;
  logic              src0_ready;
  logic [DATA_W-1:0] src1_data = '0;
  logic              src1_valid = 1'b0;
  logic              src1_ready;
  logic              uf_clr = 1'b0;
  logic [DATA_W-1:0] dac_word;
  logic              dac_load;
  logic              ws;
  logic              bclk;
  logic              bit_tick;
  logic [1:0]        underflow;
  logic              busy;

  team_06_i2s_channel_scheduler #(.DATA_W(DATA_W), .CLK_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .en(en),
    .src0_data(src0_data), .src0_valid(src0_valid), .src0_ready(src0_ready),
    .src1_data(src1_data), .src1_valid(src1_valid), .src1_ready(src1_ready),
    .uf_clr(uf_clr), .dac_word(dac_word), .dac_load(dac_load), .ws(ws),
    .bclk(bclk), .bit_tick(bit_tick), .underflow(underflow), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Waits for a dac_load sample; a missing strobe is a failed comparison.
  task automatic wait_load(input string name, input int max, output int at);
    bit seen;
    seen = 1'b0;
    at   = -1;
    for (int i = 0; i < max && !seen; i++) begin
      @(negedge clk);
      if (dac_load) begin
        seen = 1'b1;
        at   = cyc;
      end
    end
    check({name, " load seen"}, 32'(seen), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; src0_valid = 1'b0; src1_valid = 1'b0; uf_clr = 1'b0;
    tick();
    rst = 1'b0;
    tick();
  endtask

  typedef struct {
    logic              rst;
    logic              en;
    logic              v0;
    logic [DATA_W-1:0] d0;
    logic              v1;
    logic [DATA_W-1:0] d1;
    logic              uf_clr;
    logic              r0;
    logic              r1;
    logic              busy;
    logic              load;
    logic [DATA_W-1:0] word;
    logic              ws;
    logic [1:0]        uf;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t_first, t_at, t_fall, n_hi, n_lo, n_load, n_ws, n_r0;
    bit done;

    //            rst en v0 d0     v1 d1     clr  r0 r1 bsy ld word  ws uf
    vecs[0] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 2'b00};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 8'hDB, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 2'b00};
    vecs[2] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h29, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 2'b00};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 8'hEE, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 2'b00};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 2'b00};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'hDB, 1'b0, 2'b00};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'hDB, 1'b0, 2'b00};

    t_first = 0;
    @(negedge clk);

    // ---------------- table: reset, IDLE handshakes, first left load -------
    for (int i = 0; i < 7; i++) begin
      rst = vecs[i].rst; en = vecs[i].en; uf_clr = vecs[i].uf_clr;
      src0_valid = vecs[i].v0; src0_data = vecs[i].d0;
      src1_valid = vecs[i].v1; src1_data = vecs[i].d1;
      if (vecs[i].rst) begin
        en = 1'($urandom_range(0, 1)); uf_clr = 1'($urandom_range(0, 1));
        src0_valid = 1'($urandom_range(0, 1)); src0_data = 8'($urandom);
        src1_valid = 1'($urandom_range(0, 1)); src1_data = 8'($urandom);
      end
      tick();
      check($sformatf("vec%0d src0_ready", i), 32'(src0_ready), 32'(vecs[i].r0));
      check($sformatf("vec%0d src1_ready", i), 32'(src1_ready), 32'(vecs[i].r1));
      check($sformatf("vec%0d busy", i), 32'(busy), 32'(vecs[i].busy));
      check($sformatf("vec%0d dac_load", i), 32'(dac_load), 32'(vecs[i].load));
      check($sformatf("vec%0d dac_word", i), 32'(dac_word), 32'(vecs[i].word));
      check($sformatf("vec%0d ws", i), 32'(ws), 32'(vecs[i].ws));
      check($sformatf("vec%0d underflow", i), 32'(underflow), 32'(vecs[i].uf));
      check($sformatf("vec%0d bclk", i), 32'(bclk), 32'd0);
      if (i == 5) t_first = cyc;
    end

    // ---------------- normal stereo: bclk shape and right load -------------
    n_hi = 0; n_lo = 0; done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (bclk) done = 1'b1;
    end
    check("bclk rises", 32'(done), 32'd1);
    n_hi = 1;
    for (int i = 0; i < 100 && bclk; i++) begin @(negedge clk); if (bclk) n_hi++; end
    n_lo = 1;
    for (int i = 0; i < 100 && !bclk; i++) begin @(negedge clk); if (!bclk) n_lo++; end
    check("bclk high clks", 32'(n_hi), 32'(CPB / 2));
    check("bclk period", 32'(n_hi + n_lo), 32'(CPB));

    wait_load("stereo right", 2 * SLOT, t_at);
    check("stereo right spacing", 32'(t_at - t_first), 32'(SLOT));
    check("stereo right word", 32'(dac_word), 32'h29);
    check("stereo right ws", 32'(ws), 32'd1);
    check("stereo src1_ready", 32'(src1_ready), 32'd1);
    en = 1'b0;

    // ---------------- underflow: missing right sample, clear, set+clear ----
    do_reset();
    src0_valid = 1'b1; src0_data = 8'h5A; tick(); src0_valid = 1'b0;
    en = 1'b1;
    wait_load("uf left", 10, t_at);
    check("uf left word", 32'(dac_word), 32'h5A);
    check("uf left flags", 32'(underflow), 32'd0);
    wait_load("uf right", 2 * SLOT, t_at);
    check("uf right word", 32'(dac_word), 32'h00);
    check("uf right ws", 32'(ws), 32'd1);
    check("uf right flags", 32'(underflow), 32'b10);
    uf_clr = 1'b1; tick(); uf_clr = 1'b0;
    check("uf cleared", 32'(underflow), 32'b00);
    src0_valid = 1'b1; src0_data = 8'h66; tick(); src0_valid = 1'b0;
    wait_load("uf left2", 2 * SLOT, t_at);
    check("uf left2 word", 32'(dac_word), 32'h66);
    check("uf left2 flags", 32'(underflow), 32'b00);
    uf_clr = 1'b1;
    wait_load("uf set+clr", 2 * SLOT, t_at);
    check("uf set+clr flags", 32'(underflow), 32'b10);
    uf_clr = 1'b0;
    tick();
    check("uf sticky", 32'(underflow), 32'b10);
    en = 1'b0;

    // ---------------- backpressure on src0 ---------------------------------
    do_reset();
    src0_valid = 1'b1; src0_data = 8'h11; tick();
    check("bp first captured", 32'(src0_ready), 32'd0);
    src0_data = 8'h22;
    n_r0 = 0;
    for (int i = 0; i < 5; i++) begin tick(); if (src0_ready) n_r0++; end
    check("bp ready low while full", 32'(n_r0), 32'd0);
    en = 1'b1;
    tick();
    check("bp left load", 32'(dac_load), 32'd1);
    check("bp left word", 32'(dac_word), 32'h11);
    check("bp ready after consume", 32'(src0_ready), 32'd1);
    t_first = cyc;
    tick();
    check("bp second captured", 32'(src0_ready), 32'd0);
    src0_valid = 1'b0;
    src1_valid = 1'b1; src1_data = 8'hAB; tick(); src1_valid = 1'b0;
    wait_load("bp right", 2 * SLOT, t_at);
    check("bp right word", 32'(dac_word), 32'hAB);
    wait_load("bp left2", 2 * SLOT, t_at);
    check("bp left2 spacing", 32'(t_at - t_first), 32'(2 * SLOT));
    check("bp left2 word", 32'(dac_word), 32'h22);
    en = 1'b0;

    // ---------------- enable drop at bit 3 of the left slot ----------------
    do_reset();
    src0_valid = 1'b1; src0_data = 8'h33; src1_valid = 1'b1; src1_data = 8'h44;
    tick();
    src0_valid = 1'b0; src1_valid = 1'b0;
    en = 1'b1;
    wait_load("drop left", 10, t_first);
    repeat (3 * CPB + 6) @(negedge clk);
    en = 1'b0;
    n_load = 0; n_ws = 0; n_hi = 0; t_fall = -1; done = 1'b0;
    for (int i = 0; i < 2 * SLOT && !done; i++) begin
      @(negedge clk);
      if (dac_load) n_load++;
      if (ws) n_ws++;
      if (bclk) n_hi++;
      if (!busy) begin done = 1'b1; t_fall = cyc; end
    end
    check("drop idle reached", 32'(done), 32'd1);
    check("drop idle timing", 32'(t_fall - t_first), 32'(SLOT));
    check("drop no load", 32'(n_load), 32'd0);
    check("drop ws low", 32'(n_ws), 32'd0);
    check("drop bclk ran", 32'(n_hi > 0), 32'd1);
    check("drop bclk idle", 32'(bclk), 32'd0);
    check("drop src1 kept", 32'(src1_ready), 32'd0);

    // ---------------- second run: en re-asserted during DRAIN --------------
    src0_valid = 1'b1; src0_data = 8'h55; tick(); src0_valid = 1'b0;
    en = 1'b1;
    wait_load("rerun left", 10, t_first);
    check("rerun left word", 32'(dac_word), 32'h55);
    repeat (100) @(negedge clk);
    en = 1'b0;
    tick();
    check("rerun drain busy", 32'(busy), 32'd1);
    repeat (100) @(negedge clk);
    en = 1'b1;
    wait_load("rerun right", 2 * SLOT, t_at);
    check("rerun right spacing", 32'(t_at - t_first), 32'(SLOT));
    check("rerun right word", 32'(dac_word), 32'h44);
    check("rerun right ws", 32'(ws), 32'd1);

    // ---------------- mid-run reset ----------------------------------------
    src0_valid = 1'b1; src0_data = 8'h77; src1_valid = 1'b1; src1_data = 8'h88;
    tick();
    src0_valid = 1'b0; src1_valid = 1'b0;
    check("mr holds full", 32'({src0_ready, src1_ready}), 32'b00);
    repeat (10) @(negedge clk);
    rst = 1'b1; en = 1'b0;
    #1;
    check("mr async word", 32'(dac_word), 32'h00);
    check("mr async ws", 32'(ws), 32'd0);
    check("mr async busy", 32'(busy), 32'd0);
    check("mr async bclk", 32'(bclk), 32'd0);
    check("mr async load", 32'(dac_load), 32'd0);
    check("mr async uf", 32'(underflow), 32'b00);
    check("mr async ready", 32'({src0_ready, src1_ready}), 32'b11);
    #999;
    rst = 1'b0;
    src0_valid = 1'b1; src0_data = 8'hF9; tick(); src0_valid = 1'b0;
    en = 1'b1;
    wait_load("mr fresh left", 10, t_at);
    check("mr fresh word", 32'(dac_word), 32'hF9);
    check("mr fresh ws", 32'(ws), 32'd0);
    en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
